// File: rtl/velocity_cell_reader.sv
// velocity_cell_reader
// Read-side controller for one per-cell velocity RAM. Word 0 holds the particle
// count and words 1..N hold {vz, vy, vx} records. On start the count is read and
// clamped, then every record is streamed out over a valid/ready interface. A
// two-entry output FIFO absorbs the 1-cycle RAM latency so that backpressure is
// fully supported and no beat is dropped or duplicated.
//
// Ports
//   clk, rst (sync, active-low)  : clock / reset
//   start                        : 1-cycle stream request, honoured in IDLE only
//   busy, done                   : status; done pulses once per stream
//   count_err                    : sticky, stored count was above PARTICLE_NUM-1
//   particle_count               : clamped record count N
//   mem_address/rden/wren/data/q : single-port RAM port (this block only reads)
//   out_valid/ready/data/index/last : record stream toward the motion pipeline
module velocity_cell_reader #(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  count_err,
  output logic [ADDR_WIDTH-1:0] particle_count,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rden,
  output logic                  mem_wren,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_last
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_CNT  = 3'd1,
    CAP_CNT = 3'd2,
    STREAM  = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] MAX_N = ADDR_WIDTH'(PARTICLE_NUM - 1);

  state_t                state_r, state_s;
  // Read pointer is one bit wider so a full 2^ADDR_WIDTH-1 stream cannot wrap.
  logic [ADDR_WIDTH:0]   ptr_r;
  logic                  pend_r;
  logic [ADDR_WIDTH-1:0] pend_idx_r;

  logic [DATA_WIDTH-1:0] fifo_data_r [2];
  logic [ADDR_WIDTH-1:0] fifo_idx_r  [2];
  logic                  fifo_last_r [2];
  logic                  wr_sel_r, rd_sel_r;
  logic [1:0]            occ_r;

  logic [ADDR_WIDTH-1:0] raw_cnt_s, n_cap_s, addr_s;
  logic                  cnt_over_s, rden_s, issue_s, pop_s, push_s;
  logic [2:0]            slots_s;

  assign mem_wren       = 1'b0;
  assign mem_data       = '0;
  assign mem_address    = addr_s;
  assign mem_rden       = rden_s;
  assign busy           = (state_r != IDLE);
  assign done           = (state_r == DONE);
  assign out_valid      = (occ_r != 2'd0);
  assign out_data       = fifo_data_r[rd_sel_r];
  assign out_index      = fifo_idx_r[rd_sel_r];
  assign out_last       = out_valid & fifo_last_r[rd_sel_r];

  assign raw_cnt_s  = mem_q[ADDR_WIDTH-1:0];
  assign cnt_over_s = (raw_cnt_s > MAX_N);
  assign n_cap_s    = cnt_over_s ? MAX_N : raw_cnt_s;
  assign pop_s      = out_valid & out_ready;
  assign push_s     = pend_r;
  // Slots that will be committed after this cycle's pop; never exceeds 2.
  assign slots_s    = 3'(occ_r) + 3'(pend_r) - 3'(pop_s);

  // Next-state and RAM read-issue decode.
  always_comb begin
    state_s = state_r;
    rden_s  = 1'b0;
    issue_s = 1'b0;
    addr_s  = '0;
    case (state_r)
      IDLE: begin
        if (start) state_s = RD_CNT;
        else       state_s = IDLE;
      end
      RD_CNT: begin
        rden_s  = 1'b1;
        state_s = CAP_CNT;
      end
      CAP_CNT: begin
        if (n_cap_s == '0) begin
          state_s = DONE;
        end else begin
          // First record read overlaps the count capture.
          state_s = STREAM;
          rden_s  = 1'b1;
          issue_s = 1'b1;
          addr_s  = ADDR_WIDTH'(1);
        end
      end
      STREAM: begin
        if ((ptr_r <= {1'b0, particle_count}) && (slots_s < 3'd2)) begin
          rden_s  = 1'b1;
          issue_s = 1'b1;
          addr_s  = ptr_r[ADDR_WIDTH-1:0];
        end else begin
          rden_s  = 1'b0;
        end
        if (pop_s && out_last) state_s = DONE;
        else                   state_s = STREAM;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, count capture, read tracking and output FIFO registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r        <= IDLE;
      ptr_r          <= '0;
      pend_r         <= 1'b0;
      pend_idx_r     <= '0;
      count_err      <= 1'b0;
      particle_count <= '0;
      wr_sel_r       <= 1'b0;
      rd_sel_r       <= 1'b0;
      occ_r          <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_r[i] <= '0;
        fifo_idx_r[i]  <= '0;
        fifo_last_r[i] <= 1'b0;
      end
    end else begin
      state_r <= state_s;
      pend_r  <= issue_s;
      if (state_r == IDLE && start) begin
        count_err <= 1'b0;
      end
      if (state_r == CAP_CNT) begin
        particle_count <= n_cap_s;
        if (cnt_over_s) count_err <= 1'b1;
      end
      if (issue_s) begin
        ptr_r      <= {1'b0, addr_s} + (ADDR_WIDTH+1)'(1);
        pend_idx_r <= addr_s;
      end
      if (push_s) begin
        fifo_data_r[wr_sel_r] <= mem_q;
        fifo_idx_r[wr_sel_r]  <= pend_idx_r;
        fifo_last_r[wr_sel_r] <= (pend_idx_r == particle_count);
        wr_sel_r              <= ~wr_sel_r;
      end
      if (pop_s) rd_sel_r <= ~rd_sel_r;
      occ_r <= occ_r + 2'(push_s) - 2'(pop_s);
    end
  end

endmodule

// File: tb/tb_velocity_cell_reader.sv
// Directed bench for velocity_cell_reader with a behavioural 1-cycle RAM.
module tb_velocity_cell_reader;

  localparam int DW = 96;
  localparam int PN = 220;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst, start, out_ready;
  logic          busy, done, count_err, mem_rden, mem_wren;
  logic [AW-1:0] particle_count, mem_address, out_index;
  logic [DW-1:0] mem_data, mem_q, out_data;
  logic          out_valid, out_last;

  int tests = 0;
  int fails = 0;

  velocity_cell_reader #(.DATA_WIDTH(DW), .PARTICLE_NUM(PN), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .count_err(count_err), .particle_count(particle_count),
    .mem_address(mem_address), .mem_rden(mem_rden), .mem_wren(mem_wren),
    .mem_data(mem_data), .mem_q(mem_q), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [0:PN-1];

  always @(posedge clk) begin
    if (mem_rden) mem_q <= (int'(mem_address) < PN) ? ram[mem_address] : '0;
  end

  // Beat recorder, stall-stability watcher and read-address high-water mark.
  logic [DW-1:0] bdata [0:511];
  int            bidx  [0:511];
  logic          blast [0:511];
  int            beats = 0;
  int            stall_err = 0;
  int            max_addr = 0;
  logic          stalled_q = 1'b0;
  logic [DW-1:0] sd;
  logic [AW-1:0] si;
  logic          sl;

  always @(posedge clk) begin
    if (!rst) begin
      stalled_q <= 1'b0;
    end else begin
      if (stalled_q && (!out_valid || out_data !== sd || out_index !== si || out_last !== sl))
        stall_err <= stall_err + 1;
      stalled_q <= out_valid && !out_ready;
      sd <= out_data;
      si <= out_index;
      sl <= out_last;
      if (out_valid && out_ready && beats < 512) begin
        bdata[beats] <= out_data;
        bidx[beats]  <= int'(out_index);
        blast[beats] <= out_last;
        beats        <= beats + 1;
      end
      if (mem_rden && int'(mem_address) > max_addr) max_addr <= int'(mem_address);
    end
  end

  function automatic logic [DW-1:0] rec(input int i);
    return {32'hC000_0000 + i, 32'hB000_0000 + i, 32'hA000_0000 + i};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int cnt);
    ram[0] = DW'(cnt);
    for (int i = 1; i < PN; i++) ram[i] = rec(i);
  endtask

  // Pulse start in the current cycle, then count cycles until done (bounded).
  task automatic run_to_done(input int budget, output int k);
    start = 1'b1;
    step();
    start = 1'b0;
    k = 1;
    while (done !== 1'b1 && k < budget) begin
      step();
      k++;
    end
  endtask

  int base, k;

  initial begin
    rst = 1'b0; start = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < PN; i++) ram[i] = '0;
    step(); step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_rden", mem_rden, 1'b0);
    chk("rst_addr", mem_address, '0);
    chk("rst_pcount", particle_count, '0);
    chk("rst_err", count_err, 1'b0);
    chk("rst_data", out_data, '0);
    rst = 1'b1;
    step();

    // N = 3, ready high: cycle-exact latency and beat contents.
    load(3);
    out_ready = 1'b1;
    start = 1'b1;
    step();                                   // T+1
    start = 1'b0;
    chk("t1_busy", busy, 1'b1);
    chk("t1_rden", mem_rden, 1'b1);
    chk("t1_addr0", mem_address, '0);
    step();                                   // T+2
    chk("t2_rden", mem_rden, 1'b1);
    chk("t2_addr1", mem_address, DW'(1));
    step();                                   // T+3
    chk("t3_novalid", out_valid, 1'b0);
    chk("t3_pcount", particle_count, DW'(3));
    step();                                   // T+4
    chk("t4_valid", out_valid, 1'b1);
    chk("t4_data", out_data, rec(1));
    chk("t4_idx", out_index, DW'(1));
    chk("t4_last", out_last, 1'b0);
    step();                                   // T+5
    chk("t5_data", out_data, rec(2));
    chk("t5_idx", out_index, DW'(2));
    step();                                   // T+6
    chk("t6_data", out_data, rec(3));
    chk("t6_idx", out_index, DW'(3));
    chk("t6_last", out_last, 1'b1);
    step();                                   // T+7
    chk("t7_done", done, 1'b1);
    chk("t7_valid", out_valid, 1'b0);
    chk("t7_err", count_err, 1'b0);
    step();                                   // T+8
    chk("t8_busy", busy, 1'b0);
    chk("t8_done", done, 1'b0);

    // N = 0: no beats, done at T+3.
    load(0);
    base = beats;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("z1_busy", busy, 1'b1);
    step();
    chk("z2_done", done, 1'b0);
    step();
    chk("z3_done", done, 1'b1);
    chk("z3_busy", busy, 1'b1);
    chk("z3_pcount", particle_count, '0);
    chk("z3_valid", out_valid, 1'b0);
    step();
    chk("z4_busy", busy, 1'b0);
    chk("z_beats", DW'(beats - base), '0);

    // N = 5 with ready toggling 1,0,0,1,0,1,...
    load(5);
    base = beats;
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    k = 1;
    while (done !== 1'b1 && k < 200) begin
      case (k % 6)
        0, 3, 5: out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
      step();
      k++;
    end
    chk("bp_done_seen", done, 1'b1);
    chk("bp_beats", DW'(beats - base), DW'(5));
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_idx%0d", i), DW'(bidx[base+i]), DW'(i + 1));
      chk($sformatf("bp_data%0d", i), bdata[base+i], rec(i + 1));
      chk($sformatf("bp_last%0d", i), blast[base+i], (i == 4) ? 1'b1 : 1'b0);
    end
    chk("bp_stall_stable", DW'(stall_err), '0);
    chk("bp_max_addr", DW'(max_addr), DW'(5));
    step();

    // Count 250 clamps to 219 with error flag.
    load(250);
    base = beats;
    out_ready = 1'b1;
    run_to_done(400, k);
    chk("cl_done_cycle", DW'(k), DW'(4 + 219));
    chk("cl_pcount", particle_count, DW'(219));
    chk("cl_err", count_err, 1'b1);
    chk("cl_beats", DW'(beats - base), DW'(219));
    chk("cl_last_idx", DW'(bidx[beats-1]), DW'(219));
    chk("cl_last_flag", blast[beats-1], 1'b1);
    chk("cl_last_data", bdata[beats-1], rec(219));
    step();
    chk("cl_err_sticky", count_err, 1'b1);

    // N = 10, reset after the 4th beat, then restart.
    load(10);
    base = beats;
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("rs_err_cleared", count_err, 1'b0);
    k = 0;
    while (beats - base < 4 && k < 50) begin
      step();
      k++;
    end
    chk("rs_four_beats", DW'(beats - base), DW'(4));
    rst = 1'b0;
    out_ready = 1'b0;
    step();
    chk("rs_busy", busy, 1'b0);
    chk("rs_done", done, 1'b0);
    chk("rs_valid", out_valid, 1'b0);
    chk("rs_last", out_last, 1'b0);
    chk("rs_rden", mem_rden, 1'b0);
    chk("rs_wren", mem_wren, 1'b0);
    chk("rs_pcount", particle_count, '0);
    chk("rs_idx", out_index, '0);
    chk("rs_data", out_data, '0);
    chk("rs_addr", mem_address, '0);
    chk("rs_mdata", mem_data, '0);
    rst = 1'b1;
    step();
    step();
    chk("rs_idle", busy, 1'b0);
    base = beats;
    out_ready = 1'b1;
    run_to_done(100, k);
    chk("rs2_done_cycle", DW'(k), DW'(14));
    chk("rs2_beats", DW'(beats - base), DW'(10));
    chk("rs2_first_idx", DW'(bidx[base]), DW'(1));
    chk("rs2_last_idx", DW'(bidx[beats-1]), DW'(10));
    step();

    // Second start mid-stream is ignored.
    base = beats;
    start = 1'b1;
    step();
    start = 1'b0;
    k = 1;
    while (k < 5) begin
      step();
      k++;
    end
    start = 1'b1;
    step();
    start = 1'b0;
    k++;
    while (done !== 1'b1 && k < 100) begin
      step();
      k++;
    end
    chk("ms_done_cycle", DW'(k), DW'(14));
    chk("ms_beats", DW'(beats - base), DW'(10));
    step();
    chk("ms_busy_after", busy, 1'b0);
    step();
    chk("ms_no_restart", mem_rden, 1'b0);
    chk("ms_stall_stable", DW'(stall_err), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
